// File: rtl/taint_phase_pkg.sv
// -----------------------------------------------------------------------------
// taint_phase_pkg
// Shared types and helpers for the taint phase monitor.
//   phase_e        : fuzzing phase encoding (IDLE=0 .. LEAK=6)
//   MK_*           : marker instruction indices (inst[23:20])
//   MARKER_MASK /
//   MARKER_PATTERN : fixed bits of a marker instruction
//   evt_rec_t      : event record at the default widths
//   is_marker()    : marker recognition
//   phase_of()     : phase entered/left by a marker index
// -----------------------------------------------------------------------------
package taint_phase_pkg;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_INIT  = 3'd1,
        PH_BIM   = 3'd2,
        PH_VCTM  = 3'd3,
        PH_DELAY = 3'd4,
        PH_TEXE  = 3'd5,
        PH_LEAK  = 3'd6
    } phase_e;

    localparam logic [3:0] MK_VCTM_START  = 4'd0;
    localparam logic [3:0] MK_VCTM_END    = 4'd1;
    localparam logic [3:0] MK_DELAY_START = 4'd2;
    localparam logic [3:0] MK_DELAY_END   = 4'd3;
    localparam logic [3:0] MK_TEXE_START  = 4'd4;
    localparam logic [3:0] MK_TEXE_END    = 4'd5;
    localparam logic [3:0] MK_LEAK_START  = 4'd6;
    localparam logic [3:0] MK_LEAK_END    = 4'd7;
    localparam logic [3:0] MK_INIT_START  = 4'd8;
    localparam logic [3:0] MK_INIT_END    = 4'd9;
    localparam logic [3:0] MK_BIM_START   = 4'd10;
    localparam logic [3:0] MK_BIM_END     = 4'd11;

    // inst[31:24] must be zero and inst[19:0] must be 20'h02013; inst[23:20]
    // carries the marker index and is masked out here.
    localparam logic [31:0] MARKER_MASK    = 32'hFF0F_FFFF;
    localparam logic [31:0] MARKER_PATTERN = 32'h0000_2013;

    localparam int EVT_CYC_W   = 64;
    localparam int EVT_TAINT_W = 32;
    localparam int EVT_SUM_W   = 48;

    typedef struct packed {
        logic [4:0]             code;
        logic [EVT_CYC_W-1:0]   cycle;
        logic [EVT_TAINT_W-1:0] taint;
        logic [EVT_SUM_W-1:0]   taint_sum;
    } evt_rec_t;

    function automatic logic is_marker(input logic [31:0] inst);
        return ((inst & MARKER_MASK) == MARKER_PATTERN) && (inst[23:20] <= MK_BIM_END);
    endfunction

    function automatic phase_e phase_of(input logic [3:0] idx);
        case (idx)
            MK_VCTM_START,  MK_VCTM_END:  return PH_VCTM;
            MK_DELAY_START, MK_DELAY_END: return PH_DELAY;
            MK_TEXE_START,  MK_TEXE_END:  return PH_TEXE;
            MK_LEAK_START,  MK_LEAK_END:  return PH_LEAK;
            MK_INIT_START,  MK_INIT_END:  return PH_INIT;
            MK_BIM_START,   MK_BIM_END:   return PH_BIM;
            default:                      return PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/taint_phase_monitor_evt_fifo.sv
// -----------------------------------------------------------------------------
// evt_fifo
// Synchronous FIFO with two push ports and one pop port.
//   clock, reset : clock, synchronous active-low reset (pointers only)
//   push0, d0    : first write of the cycle (lands first)
//   push1, d1    : second write of the cycle (only meaningful with push0)
//   pop          : consumer takes the head (ignored while empty)
//   head, valid  : head record (zero while empty) and non-empty flag
//   free         : free slots, counting this cycle's pop
// The writer must keep pushes within 'free'; no overflow check is made here.
// -----------------------------------------------------------------------------
module evt_fifo
    import taint_phase_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = evt_rec_t
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push0,
    input  T                         d0,
    input  logic                     push1,
    input  T                         d1,
    input  logic                     pop,
    output T                         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          pop_ok;

    always_comb begin
        mem_d  = mem_q;
        pop_ok = pop && (cnt_q != '0);
        if (push0) mem_d[wr_q] = d0;
        if (push1) mem_d[wr_q + AW'(1)] = d1;
        wr_d  = wr_q + AW'(push0) + AW'(push1);
        rd_d  = rd_q + AW'(pop_ok);
        cnt_d = cnt_q + (AW+1)'(push0) + (AW+1)'(push1) - (AW+1)'(pop_ok);
    end

    assign valid = (cnt_q != '0);
    assign head  = valid ? mem_q[rd_q] : '0;
    assign free  = (AW+1)'(DEPTH) - cnt_q + (AW+1)'(pop_ok);

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is never reset; empty entries are masked at the head.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/taint_phase_monitor.sv
// -----------------------------------------------------------------------------
// taint_phase_monitor
// Watches the ROB slot-0 enqueue/commit streams for marker instructions,
// tracks the fuzzing phase, measures base/variant taint divergence and queues
// timestamped event records for the bench logger.
//   clock, reset        : clock, synchronous active-low reset
//   enq_valid/enq_inst  : ROB slot-0 enqueue stream
//   deq_valid/deq_inst  : ROB slot-0 commit stream
//   taint_base/vnt      : taint_sum of base and variant DUTs
//   evt_valid/evt_ready : event FIFO head handshake
//   evt_code            : {commit, marker_idx}
//   evt_cycle/taint     : timestamp and taint metric of the head event
//   evt_taint_sum       : accumulated phase diff (0 unless TAINT_PHASE_SUM_EN)
//   phase               : current phase
//   drop_cnt            : saturating count of records lost to a full FIFO
// Build option: define TAINT_PHASE_SUM_EN to add the per-phase diff sum.
// -----------------------------------------------------------------------------
module taint_phase_monitor
    import taint_phase_pkg::*;
#(
    parameter int TAINT_W    = 32,
    parameter int CYC_W      = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_W     = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enq_valid,
    input  logic [31:0]        enq_inst,
    input  logic               deq_valid,
    input  logic [31:0]        deq_inst,
    input  logic [TAINT_W-1:0] taint_base,
    input  logic [TAINT_W-1:0] taint_vnt,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [4:0]         evt_code,
    output logic [CYC_W-1:0]   evt_cycle,
    output logic [TAINT_W-1:0] evt_taint,
    output logic [47:0]        evt_taint_sum,
    output logic [2:0]         phase,
    output logic [DROP_W-1:0]  drop_cnt
);

    localparam int SUM_W = 48;
    localparam int FW    = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [4:0]         code;
        logic [CYC_W-1:0]   cycle;
        logic [TAINT_W-1:0] taint;
`ifdef TAINT_PHASE_SUM_EN
        logic [SUM_W-1:0]   taint_sum;
`endif
    } rec_t;

    function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] a,
                                                       input logic [1:0]        b);
        logic [DROP_W:0] s;
        s = {1'b0, a} + (DROP_W+1)'(b);
        return s[DROP_W] ? '1 : s[DROP_W-1:0];
    endfunction

`ifdef TAINT_PHASE_SUM_EN
    function automatic logic [SUM_W-1:0] sat_add_sum(input logic [SUM_W-1:0]   a,
                                                     input logic [TAINT_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + (SUM_W+1)'(b);
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    logic [SUM_W-1:0] sum_q, sum_d, cur_sum;
`endif

    logic [CYC_W-1:0]   cnt_q, cnt_d;
    phase_e             phase_q, phase_d;
    logic [TAINT_W-1:0] max_q, max_d, cur_max;
    logic [DROP_W-1:0]  drop_q, drop_d;

    logic               enq_mk, deq_mk, in_phase;
    logic [3:0]         enq_idx, deq_idx;
    logic [TAINT_W-1:0] diff;
    rec_t               com_rec, enq_rec, d0, head;
    logic               push0, push1;
    logic [FW-1:0]      free;
    logic [1:0]         n_drop;

    assign enq_mk   = enq_valid && is_marker(enq_inst);
    assign deq_mk   = deq_valid && is_marker(deq_inst);
    assign enq_idx  = enq_inst[23:20];
    assign deq_idx  = deq_inst[23:20];
    assign diff     = (taint_base >= taint_vnt) ? (taint_base - taint_vnt)
                                                : (taint_vnt - taint_base);
    assign in_phase = (phase_q != PH_IDLE);

    // Phase tracking and per-phase accumulation.
    always_comb begin
        cnt_d   = cnt_q + CYC_W'(1);
        phase_d = phase_q;
        max_d   = max_q;
        // Running max as it stands after this cycle; end records report it.
        cur_max = (in_phase && (diff > max_q)) ? diff : max_q;
`ifdef TAINT_PHASE_SUM_EN
        sum_d   = sum_q;
        cur_sum = in_phase ? sat_add_sum(sum_q, diff) : sum_q;
`endif
        if (deq_mk && !deq_idx[0]) begin
            // A start marker restarts the metrics from zero, even mid-phase.
            phase_d = phase_of(deq_idx);
            max_d   = '0;
`ifdef TAINT_PHASE_SUM_EN
            sum_d   = '0;
`endif
        end else begin
            if (in_phase) begin
                max_d = cur_max;
`ifdef TAINT_PHASE_SUM_EN
                sum_d = cur_sum;
`endif
            end
            // Only the end marker of the current phase closes it.
            if (deq_mk && (phase_of(deq_idx) == phase_q)) phase_d = PH_IDLE;
        end
    end

    // Record building and FIFO write arbitration.
    always_comb begin
        com_rec       = '0;
        com_rec.code  = {1'b1, deq_idx};
        com_rec.cycle = cnt_q;
        com_rec.taint = deq_idx[0] ? cur_max : diff;
`ifdef TAINT_PHASE_SUM_EN
        com_rec.taint_sum = deq_idx[0] ? cur_sum : '0;
`endif
        enq_rec       = '0;
        enq_rec.code  = {1'b0, enq_idx};
        enq_rec.cycle = cnt_q;
        enq_rec.taint = diff;

        // The commit record always takes the first slot.
        d0     = deq_mk ? com_rec : enq_rec;
        push0  = (deq_mk || enq_mk) && (free >= FW'(1));
        push1  = deq_mk && enq_mk && (free >= FW'(2));
        n_drop = (2'(deq_mk) + 2'(enq_mk)) - (2'(push0) + 2'(push1));
        drop_d = sat_add_drop(drop_q, n_drop);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q   <= '0;
            phase_q <= PH_IDLE;
            max_q   <= '0;
            drop_q  <= '0;
`ifdef TAINT_PHASE_SUM_EN
            sum_q   <= '0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            max_q   <= max_d;
            drop_q  <= drop_d;
`ifdef TAINT_PHASE_SUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (rec_t)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push0 (push0),
        .d0    (d0),
        .push1 (push1),
        .d1    (enq_rec),
        .pop   (evt_ready),
        .head  (head),
        .valid (evt_valid),
        .free  (free)
    );

    assign evt_code  = head.code;
    assign evt_cycle = head.cycle;
    assign evt_taint = head.taint;
`ifdef TAINT_PHASE_SUM_EN
    assign evt_taint_sum = head.taint_sum;
`else
    assign evt_taint_sum = '0;
`endif
    assign phase    = phase_q;
    assign drop_cnt = drop_q;

endmodule

// File: doc/taint_phase_monitor.md
Name: taint_phase_monitor

Overview:
- Sits between the two DUT instances (base and variant) and the testbench logging layer.
- Watches the ROB enqueue and commit marker streams for the marker instructions and tracks the current fuzzing phase.
- Measures the base/variant taint divergence per phase.
- Emits timestamped event records through a valid/ready FIFO, so the bench logger only drains records and never decodes pipeline signals.

Parameters:
- TAINT_W, 32: width of each taint_sum input.
- CYC_W, 64: width of the free-running cycle counter and event timestamps.
- FIFO_DEPTH, 8: event FIFO entries; must be a power of two and at least 2.
- DROP_W, 16: width of the saturating dropped-event counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous reset, active-low
- enq_valid  in  1  ROB slot-0 enqueue valid
- enq_inst  in  32  ROB slot-0 enqueue debug instruction
- deq_valid  in  1  ROB slot-0 commit valid
- deq_inst  in  32  ROB slot-0 commit debug instruction
- taint_base  in  TAINT_W  base DUT taint_sum
- taint_vnt  in  TAINT_W  variant DUT taint_sum
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head
- evt_code  out  5  {commit, marker_idx[3:0]}
- evt_cycle  out  CYC_W  cycle stamp of the event
- evt_taint  out  TAINT_W  taint metric of the event
- evt_taint_sum  out  48  phase accumulated diff (optional feature)
- phase  out  3  current phase encoding
- drop_cnt  out  DROP_W  saturating count of dropped events

Behaviour:
- Reset: when reset==0 at a posedge, all state clears.
  - Cleared: cycle counter 0, FIFO empty, evt_valid 0, phase IDLE(0), drop_cnt 0, phase max and sum 0.
  - Registered output fields read 0 while empty.
  - Reset asserted mid-operation discards buffered events with no flush.
- Cycle counter: increments every clock out of reset and wraps at 2^CYC_W.
- Marker decode (combinational):
  - An instruction is a marker iff inst[31:24]==0 and inst[19:0]==20'h02013 and idx=inst[23:20] is at most 11.
  - Indices: 0/1 VCTM start/end, 2/3 DELAY, 4/5 TEXE, 6/7 LEAK, 8/9 INIT, 10/11 BIM.
  - idx 12–15 is not a marker.
- diff = |taint_base − taint_vnt|, computed unsigned, TAINT_W bits, no overflow possible.
- Phase FSM, advanced only by commit markers:
  - States: IDLE=0, INIT=1, BIM=2, VCTM=3, DELAY=4, TEXE=5, LEAK=6.
  - An even idx commit enters the matching phase from any state, and resets phase_max and phase_sum to 0 that cycle.
  - An odd idx commit returns to IDLE only if it matches the current phase; otherwise phase is unchanged but the event is still recorded.
  - Enqueue markers never change phase.
- Phase accumulation: in a non-IDLE phase, phase_max = max(phase_max, diff) every cycle, and this cycle's diff is included.
- Event record fields:
  - evt_cycle = counter value in the cycle the marker is seen.
  - Commit-end events: evt_taint = phase_max including the current cycle's diff.
  - All other events: evt_taint = current diff.
- FIFO write rules:
  - FIFO writes appear at the head at the earliest one cycle after the marker.
  - Up to two writes per cycle: when both fire, the commit record is written before the enq record.
  - With one free slot, the commit record is written and the enq record is dropped.
  - Free slots count the same-cycle pop: a full FIFO with evt_valid&evt_ready accepts one write.
  - Each dropped record increments drop_cnt, which saturates at all-ones.
- FIFO read: the head is held stable while evt_valid && !evt_ready; a pop occurs on evt_valid&&evt_ready.

Optional Feature:
- Macro: TAINT_PHASE_SUM_EN.
- Defined:
  - phase_sum accumulates diff every in-phase cycle, saturating at 2^48−1.
  - Commit-end records carry phase_sum (including the current cycle) on evt_taint_sum.
  - Other records carry 0 on evt_taint_sum.
- Undefined: no accumulator or FIFO storage is built, and evt_taint_sum is tied to 0.

Decomposition:
- Package taint_phase_pkg:
  - phase_e enum.
  - Marker index localparams (MK_VCTM_START, … MK_BIM_END).
  - MARKER_MASK/MARKER_PATTERN constants.
  - evt_rec_t struct {code, cycle, taint, taint_sum}.
  - is_marker() function.
- Sub-module evt_fifo: a dual-push, single-pop synchronous FIFO parameterised on depth and evt_rec_t, exposing a free-slot count.

Test Plan:
- Reset, then deq_inst=0x00802013 at cycle 5 and 0x00902013 at cycle 9, with taint_base=10/vnt=3 and then base=2/vnt=20 → phase 0→1→0.
  - Record 1: code 0x18, cycle 5, taint 7.
  - Record 2: code 0x19, cycle 9, taint 18.
- Same cycle enq=0x00002013 and deq=0x00402013, FIFO empty → two records in order: 0x14 then 0x00.
- Hold evt_ready=0 and inject 10 enq markers → 8 records retained, drop_cnt=2, and the head is stable across cycles.
- FIFO full and popping, while enq and deq markers arrive together → commit record accepted, enq dropped, drop_cnt+1.
- Non-markers 0x00C02013 and 0x01002013, and a mismatched end 0x00302013 while in INIT → no record for the non-markers; the mismatched end records code 0x13 with phase staying 1.
- Reset pulsed while 3 records are buffered → evt_valid=0 next cycle; counter, drop_cnt and phase all 0.
- With TAINT_PHASE_SUM_EN and diff=5 for 4 cycles → end record evt_taint_sum=20.
